ram_port_arbiter: RTL

Shares the single data port of the 32-bit data RAM between the CPU load/store path and a debug/loader port used to preload or inspect data memory. It sits between the CPU top level and the RAM instance. Each requester gets a req/ack handshake, and the CPU gets a stall signal that gates PC increment while its access is pending. The RAM has a registered address and an unregistered output, so a read returns data one cycle after the address is clocked.

---
 rtl/ram_port_arbiter_pkg.sv | 20 ++
 rtl/ram_port_arbiter_rr_grant2.sv | 18 +
 rtl/ram_port_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared encodings and width defaults for the data RAM port arbiter
package ram_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RESP     = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } owner_t;

endpackage

// File: rtl/ram_port_arbiter_rr_grant2.sv
// rtl/ram_port_arbiter_rr_grant2.sv - two-requester round-robin picker (a = CPU, b = DBG)
module rr_grant2
    import ram_port_arbiter_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    assign grant_valid = req_a | req_b;

    // On a tie the requester that did not win last time goes first.
    assign grant_id = (req_a & req_b) ? ~last_grant
                                      : (req_b ? OWNER_DBG : OWNER_CPU);

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares the data RAM port between the CPU load/store path and the debug loader
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_rden,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              arb_busy
);

    arb_state_t state;
    owner_t     owner;
    owner_t     last_grant;

    logic              grant_valid;
    logic              grant_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_grant2 u_rr_grant2 (
        .req_a       (cpu_req),
        .req_b       (dbg_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (grant_id == OWNER_DBG) begin
            sel_we    = dbg_we;
            sel_addr  = dbg_addr;
            sel_wdata = dbg_wdata;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_ack;
    assign arb_busy  = (state != IDLE);

    // RAM drive registers double as the latched address/data of the granted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWNER_CPU;
            last_grant  <= OWNER_DBG;
            cpu_ack     <= 1'b0;
            dbg_ack     <= 1'b0;
            cpu_rdata   <= '0;
            dbg_rdata   <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_rden    <= 1'b0;
            ram_wren    <= 1'b0;
        end else begin
            ram_rden <= 1'b0;
            ram_wren <= 1'b0;
            cpu_ack  <= 1'b0;
            dbg_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner       <= owner_t'(grant_id);
                        last_grant  <= owner_t'(grant_id);
                        ram_address <= sel_addr;
                        ram_data    <= sel_wdata;
                        if (sel_we) begin
                            ram_wren <= 1'b1;
                            cpu_ack  <= (grant_id == OWNER_CPU);
                            dbg_ack  <= (grant_id == OWNER_DBG);
                            state    <= WR_ISSUE;
                        end else begin
                            ram_rden <= 1'b1;
                            state    <= RD_ISSUE;
                        end
                    end
                end
                WR_ISSUE: state <= IDLE;
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    if (owner == OWNER_DBG) begin
                        dbg_rdata <= ram_q;
                        dbg_ack   <= 1'b1;
                    end else begin
                        cpu_rdata <= ram_q;
                        cpu_ack   <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
